seq_multiplier: RTL and testbench

Parametrised sequential shift-add multiplier. It is the multi-cycle successor to the 4-bit combinational multiplier and trades latency for area. The block accepts an operand pair on a start/busy/done handshake, supports unsigned or two's-complement operands selected per operation, and holds the full-width product until the next result completes. It is used wherever a WIDTH×WIDTH product is needed once every WIDTH+1 cycles.

---
 rtl/seq_multiplier.sv | 113 +++++++++++
 tb/tb_seq_multiplier.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product over WIDTH add cycles,
// unsigned or two's complement per operation, start/busy/done handshake.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic             neg;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic             neg_in;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    result;

  // Signed operands are reduced to magnitudes so the datapath is purely unsigned;
  // the most negative value maps to 2^(WIDTH-1), which still fits in WIDTH bits.
  always_comb begin
    a_mag    = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
    b_mag    = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;
    a_sel    = signed_mode ? a_mag : A;
    b_sel    = signed_mode ? b_mag : B;
    neg_in   = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
    acc_next = acc + (mplier[0] ? mcand : '0);
    result   = neg ? (~acc + PW'(1)) : acc;
  end

  // The final add lands on the edge entering S_DONE; the sign fix-up and the done
  // pulse happen on the edge leaving it, which is also where a back-to-back start is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      count   <= '0;
      neg     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a_sel};
            mplier <= b_sel;
            neg    <= neg_in;
            acc    <= '0;
            count  <= CW'(WIDTH);
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - CW'(1);
          if (count == CW'(1)) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          product <= result;
          done    <= 1'b1;
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a_sel};
            mplier <= b_sel;
            neg    <= neg_in;
            acc    <= '0;
            count  <= CW'(WIDTH);
            busy   <= 1'b1;
            state  <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed corner cases plus random operands
// checked against an integer-arithmetic reference model.
module tb_seq_multiplier;

  localparam int W = 4;

  logic           clk;
  logic           reset;
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int checks;
  int failures;
  logic [2*W-1:0] last_product;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: exact integer product, reduced modulo 2^(2W).
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sm);
    longint sa;
    longint sb;
    longint p;
    sa = sm ? longint'($signed(a)) : longint'(a);
    sb = sm ? longint'($signed(b)) : longint'(b);
    p  = sa * sb;
    return p[2*W-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation from IDLE; optionally pulses start with junk operands mid-run.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                        input logic [2*W-1:0] expected, input bit disturb, input string name);
    int  k;
    int  busy_cnt;
    bit  held_ok;
    A = a;
    B = b;
    signed_mode = sm;
    start = 1'b1;
    step();
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    signed_mode = 1'($urandom);
    k = 0;
    busy_cnt = 0;
    held_ok = 1'b1;
    while (!done && k < 3 * W) begin
      if (busy) busy_cnt++;
      if (product !== last_product) held_ok = 1'b0;
      if (disturb && k == W / 2) begin
        start = 1'b1;
        A = W'($urandom);
        B = W'($urandom);
        signed_mode = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      step();
      k++;
    end
    checks++;
    if (k !== W + 1) begin
      failures++;
      $display("[TB] FAIL %s latency: got %0d expected %0d", name, k, W + 1);
    end
    checks++;
    if (product !== expected) begin
      failures++;
      $display("[TB] FAIL %s product: got %h expected %h", name, product, expected);
    end
    checks++;
    if (busy_cnt !== W) begin
      failures++;
      $display("[TB] FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, W);
    end
    checks++;
    if (held_ok !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s product_held: got changed expected %h", name, last_product);
    end
    last_product = expected;
    step();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s done_fall: got %b expected 0", name, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    signed_mode = 1'b0;
    A = '0;
    B = '0;
    last_product = '0;
    step();
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_done: got %b expected 0", done);
    end
    checks++;
    if (product !== '0) begin
      failures++;
      $display("[TB] FAIL reset_product: got %h expected 00", product);
    end
    reset = 1'b1;
  endtask

  task automatic test_unsigned();
    logic [W-1:0] a;
    logic [W-1:0] b;
    run_op(4'b0111, 4'b0110, 1'b0, 8'h2A, 1'b0, "u_7x6");
    run_op(4'b1111, 4'b1111, 1'b0, 8'hE1, 1'b0, "u_15x15");
    run_op(4'b0101, 4'b1110, 1'b0, 8'h46, 1'b0, "u_5x14");
    run_op(4'b0000, 4'b0010, 1'b0, 8'h00, 1'b0, "u_0x2");
    for (int i = 0; i < 12; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      run_op(a, b, 1'b0, model(a, b, 1'b0), 1'b0, "u_rand");
    end
  endtask

  task automatic test_signed();
    logic [W-1:0] a;
    logic [W-1:0] b;
    run_op(4'b0101, 4'b1110, 1'b1, 8'hF6, 1'b0, "s_5xm2");
    run_op(4'b1000, 4'b1000, 1'b1, 8'h40, 1'b0, "s_m8xm8");
    run_op(4'b1000, 4'b0111, 1'b1, 8'hC8, 1'b0, "s_m8x7");
    for (int i = 0; i < 12; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      run_op(a, b, 1'b1, model(a, b, 1'b1), 1'b0, "s_rand");
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]   as [3] = '{4'd4, 4'd5, 4'd4};
    logic [W-1:0]   bs [3] = '{4'd1, 4'd3, 4'd10};
    logic [2*W-1:0] ex [3] = '{8'h04, 8'h0F, 8'h28};
    A = as[0];
    B = bs[0];
    signed_mode = 1'b0;
    start = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      for (int k = 1; k < W; k++) begin
        A = W'($urandom);
        B = W'($urandom);
        signed_mode = 1'($urandom);
        step();
      end
      signed_mode = 1'b0;
      if (i < 2) begin
        A = as[i+1];
        B = bs[i+1];
      end else begin
        start = 1'b0;
      end
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL b2b_gap%0d: got done=%b busy=%b expected done=0 busy=0", i, done, busy);
      end
      step();
      checks++;
      if (done !== 1'b1) begin
        failures++;
        $display("[TB] FAIL b2b_done%0d: got %b expected 1", i, done);
      end
      checks++;
      if (product !== ex[i]) begin
        failures++;
        $display("[TB] FAIL b2b_product%0d: got %h expected %h", i, product, ex[i]);
      end
      checks++;
      if (busy !== (i < 2)) begin
        failures++;
        $display("[TB] FAIL b2b_busy%0d: got %b expected %b", i, busy, (i < 2));
      end
    end
    last_product = ex[2];
    step();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_done_fall: got %b expected 0", done);
    end
  endtask

  task automatic test_start_during_run();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sm;
    run_op(4'b0011, 4'b1101, 1'b0, 8'h27, 1'b1, "busy_start_u");
    for (int i = 0; i < 4; i++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      sm = 1'($urandom);
      run_op(a, b, sm, model(a, b, sm), 1'b1, "busy_start_rand");
    end
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    bit saw_busy;
    A = 4'b0111;
    B = 4'b0111;
    signed_mode = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_ctrl: got busy=%b done=%b expected busy=0 done=0", busy, done);
    end
    checks++;
    if (product !== '0) begin
      failures++;
      $display("[TB] FAIL abort_product: got %h expected 00", product);
    end
    step();
    reset = 1'b1;
    last_product = '0;
    saw_done = 1'b0;
    saw_busy = 1'b0;
    for (int k = 0; k < W + 3; k++) begin
      step();
      if (done) saw_done = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || saw_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_after_release: got done=%b busy=%b expected 0 0", saw_done, saw_busy);
    end
    run_op(4'b1001, 4'b0110, 1'b1, 8'hD6, 1'b0, "after_abort");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_start_during_run();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
